// File: rtl/scan_sequencer.sv
// scan_sequencer: four-digit display scan controller.
// Snapshots THOU/HUND/TENS/ONES at the start of each frame and time-multiplexes
// them onto DIG with a one-hot SEL. Each digit is held for DWELL cycles.
// Optional leading-zero blanking is enabled by defining SCAN_LZB_EN.
module scan_sequencer #(
    parameter int unsigned DWELL = 16,
    parameter logic [4:0]  BLANK = 5'h1F
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  logic [4:0] THOU,
    input  logic [4:0] HUND,
    input  logic [4:0] TENS,
    input  logic [4:0] ONES,
    output logic [4:0] DIG,
    output logic [3:0] SEL,
    output logic       FRAME
);

    localparam int unsigned    CW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]  LAST    = CW'(DWELL - 1);
    localparam logic           ST_IDLE = 1'b0;
    localparam logic           ST_SCAN = 1'b1;

    logic                 state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0][4:0]      snap_q, snap_d;
    logic                 frame_q, frame_d;
    logic                 capture;
    logic                 last_cyc;
    logic [3:0]           blank;

    // A new frame starts from IDLE, or back-to-back at the end of a frame, when EN is high.
    assign last_cyc = (state_q == ST_SCAN) && (cnt_q == LAST) && (idx_q == 2'd0);
    assign capture  = EN && ((state_q == ST_IDLE) || last_cyc);

    // Next-state logic: dwell counting, digit index stepping and snapshot capture.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        frame_d = capture;
        if (capture) begin
            state_d = ST_SCAN;
            idx_d   = 2'd3;
            cnt_d   = '0;
            snap_d  = {THOU, HUND, TENS, ONES};
        end else if (state_q == ST_SCAN) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                if (idx_q == 2'd0) begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd3;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset forces IDLE and clears the snapshot.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd3;
            cnt_q   <= '0;
            snap_q  <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            frame_q <= frame_d;
        end
    end

`ifdef SCAN_LZB_EN
    logic [3:0] blank_q, blank_d;

    // Blank flags are derived from the raw inputs at the capture edge so they
    // always describe the same snapshot that is being displayed.
    always_comb begin
        blank_d = blank_q;
        if (capture) begin
            blank_d[3] = (THOU == 5'd0);
            blank_d[2] = blank_d[3] && (HUND == 5'd0);
            blank_d[1] = blank_d[2] && (TENS == 5'd0);
            blank_d[0] = 1'b0;
        end
    end

    // Blank flag registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) blank_q <= '0;
        else      blank_q <= blank_d;
    end

    assign blank = blank_q;
`else
    assign blank = '0;
`endif

    // Outputs decode registered state only, so there is no input-to-output path
    // and reset reaches the pins without a clock edge.
    always_comb begin
        SEL = 4'b0000;
        DIG = BLANK;
        if (state_q == ST_SCAN) begin
            SEL = 4'b0001 << idx_q;
            DIG = blank[idx_q] ? BLANK : snap_q[idx_q];
        end
    end

    assign FRAME = frame_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: two instances (DWELL=2 and DWELL=1) share stimulus
// and are compared each cycle against a frame-position reference model.
module tb_scan_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       EN;
    logic [4:0] THOU, HUND, TENS, ONES;
    logic [4:0] dig_a, dig_b;
    logic [3:0] sel_a, sel_b;
    logic       frm_a, frm_b;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    scan_sequencer #(.DWELL(2), .BLANK(5'h1F)) u_dw2 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .THOU(THOU), .HUND(HUND), .TENS(TENS), .ONES(ONES),
        .DIG(dig_a), .SEL(sel_a), .FRAME(frm_a)
    );

    scan_sequencer #(.DWELL(1), .BLANK(5'h1F)) u_dw1 (
        .CLK(CLK), .RST(RST), .EN(EN),
        .THOU(THOU), .HUND(HUND), .TENS(TENS), .ONES(ONES),
        .DIG(dig_b), .SEL(sel_b), .FRAME(frm_b)
    );

    // Reference model: per instance, whether a frame is running, the cycle
    // position within it, and the four snapshot digits (index 3 = THOU).
    int         dw  [2] = '{2, 1};
    bit         act [2];
    int         pos [2];
    logic [4:0] snap[2][4];

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            act[k] = 1'b0;
            pos[k] = 0;
            for (int d = 0; d < 4; d++) snap[k][d] = 5'd0;
        end
    endtask

    task automatic m_take(input int k);
        snap[k][3] = THOU; snap[k][2] = HUND; snap[k][1] = TENS; snap[k][0] = ONES;
    endtask

    task automatic m_clock();
        for (int k = 0; k < 2; k++) begin
            if (!act[k]) begin
                if (EN) begin act[k] = 1'b1; pos[k] = 0; m_take(k); end
            end else begin
                pos[k]++;
                if (pos[k] == 4 * dw[k]) begin
                    if (EN) begin pos[k] = 0; m_take(k); end
                    else act[k] = 1'b0;
                end
            end
        end
    endtask

    // A digit is a leading zero when it and every more significant digit is 0.
    function automatic bit m_blanked(input int k, input int d);
`ifdef SCAN_LZB_EN
        if (d == 0) return 1'b0;
        for (int j = d; j < 4; j++) if (snap[k][j] != 5'd0) return 1'b0;
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input int k, input logic [4:0] obs, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dwell=%0d t=%0t: got %h expected %h", tag, dw[k], $time, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [4:0] e_sel, e_dig, e_frm;
            int d;
            e_sel = 5'd0; e_dig = 5'h1F; e_frm = 5'd0;
            if (act[k]) begin
                d     = 3 - pos[k] / dw[k];
                e_sel = 5'd1 << d;
                e_dig = m_blanked(k, d) ? 5'h1F : snap[k][d];
                e_frm = (pos[k] == 0) ? 5'd1 : 5'd0;
            end
            chk("SEL",   k, (k == 0) ? {1'b0, sel_a} : {1'b0, sel_b}, e_sel);
            chk("DIG",   k, (k == 0) ? dig_a : dig_b, e_dig);
            chk("FRAME", k, (k == 0) ? {4'd0, frm_a} : {4'd0, frm_b}, e_frm);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        m_clock();
        @(negedge CLK);
        check_all();
    endtask

    task automatic set_dig(input logic [4:0] t, input logic [4:0] h, input logic [4:0] te, input logic [4:0] o);
        THOU = t; HUND = h; TENS = te; ONES = o;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b0;
        set_dig(0, 0, 0, 0);
        m_reset();
        // Reset then idle with EN low.
        #2 RST = 1'b0;
        #1 check_all();
        repeat (3) begin @(negedge CLK); check_all(); end
        RST = 1'b1;
        repeat (10) step();

        // Single frame from a one-cycle EN pulse.
        set_dig(1, 2, 3, 4); EN = 1'b1;
        step();
        EN = 1'b0;
        repeat (10) step();

        // Snapshot coherence: inputs change mid-frame with EN held high.
        set_dig(5, 6, 7, 8); EN = 1'b1;
        repeat (4) step();
        set_dig(9, 9, 9, 9);
        repeat (20) step();
        EN = 1'b0;
        repeat (10) step();

        // Leading-zero cases.
        set_dig(0, 0, 4, 0); EN = 1'b1;
        step();
        EN = 1'b0;
        repeat (9) step();
        set_dig(0, 0, 0, 0); EN = 1'b1;
        step();
        EN = 1'b0;
        repeat (9) step();

        // Reset mid-frame while the DWELL=2 instance shows HUND.
        set_dig(1, 2, 3, 4); EN = 1'b1;
        repeat (3) step();
        #2 RST = 1'b0;
        #1 m_reset();
        check_all();
        @(negedge CLK);
        check_all();
        RST = 1'b1;
        step();

        // Continuous scanning.
        repeat (16) step();

        // Randomized stretch with biased zeros to exercise blanking.
        repeat (400) begin
            EN = ($urandom_range(0, 3) != 0);
            THOU = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            HUND = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            TENS = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            ONES = 5'($urandom_range(0, 31));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
